// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between NoC packet sources and the output link.
// slave: arbiter side; master: requesters plus downstream side.
interface noc_port_arbiter_if #(
   parameter int N_REQ = 5,
   parameter int WIDTH = 11
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic                   out_ready;
   logic [2:0]             grant_id;
   logic [15:0]            pkt_count;

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, grant_id, pkt_count
   );

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, grant_id, pkt_count
   );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one NoC output link among N_REQ sources.
// Ports: clk, rst_n (async low), bus (slave: req_*/out_*/grant_id/pkt_count).
module noc_port_arbiter #(
   parameter int N_REQ = 5,
   parameter int WIDTH = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   noc_port_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e           state_q;
   logic [2:0]       ptr_q;
   logic [2:0]       ptr_d;
   logic [2:0]       win;
   logic [2:0]       gid_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [15:0]      cnt_q;
   logic [N_REQ-1:0] rdy;
   logic             found;
   logic             free;
   logic             in_xfer;
   logic             out_xfer;
   int               s;
   int               nxt;

   // Search starts at ptr and wraps; the first valid requester wins.
   always_comb begin
      free  = (state_q == EMPTY) || bus.out_ready;
      found = 1'b0;
      win   = '0;
      s     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         s = int'(ptr_q) + k;
         if (s >= N_REQ) s = s - N_REQ;
         if (!found && bus.req_valid[s[IW-1:0]]) begin
            found = 1'b1;
            win   = s[2:0];
         end
      end
      in_xfer = found && free && rst_n;
      rdy     = '0;
      if (in_xfer) rdy[win[IW-1:0]] = 1'b1;
      nxt = int'(win) + 1;
      if (nxt >= N_REQ) nxt = 0;
      ptr_d    = nxt[2:0];
      data_d   = bus.req_data[int'(win)*WIDTH +: WIDTH];
      out_xfer = (state_q == FULL) && bus.out_ready;
   end

   // A new packet may replace the departing one in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         gid_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (in_xfer) begin
            state_q <= FULL;
            data_q  <= data_d;
            gid_q   <= win;
            ptr_q   <= ptr_d;
         end else if (out_xfer) begin
            state_q <= EMPTY;
         end
         if (out_xfer) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.req_ready = rdy;
   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.grant_id  = gid_q;
   assign bus.pkt_count = cnt_q;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Randomized and directed bench for noc_port_arbiter.
// Scoreboard queue filled by the driver, drained by a negedge monitor.
module tb_noc_port_arbiter;
   localparam int N = 5;
   localparam int W = 11;

   typedef struct {
      logic [W-1:0] d;
      logic [2:0]   g;
   } exp_t;

   logic clk;
   logic rst_n;

   noc_port_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   noc_port_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   exp_t         sb[$];
   logic [2:0]   got_gid[$];
   logic [W-1:0] got_data[$];
   logic [15:0]  m_cnt;
   int           m_ptr;
   bit           m_full;
   bit           pend_v[N];
   logic [W-1:0] pend_d[N];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                  $time);
      end
   endtask

   // Monitor: pkt_count and every delivered packet against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      check("pkt_count", 32'(bus.pkt_count), 32'(m_cnt));
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_delivery", 32'(bus.out_data), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e.d));
            check("grant_id", 32'(bus.grant_id), 32'(e.g));
         end
         got_gid.push_back(bus.grant_id);
         got_data.push_back(bus.out_data);
         m_cnt = m_cnt + 16'd1;
      end
   end

   task automatic clear_pend();
      for (int i = 0; i < N; i++) begin
         pend_v[i] = 1'b0;
         pend_d[i] = '0;
      end
   endtask

   task automatic model_reset();
      sb.delete();
      got_gid.delete();
      got_data.delete();
      m_cnt  = '0;
      m_ptr  = 0;
      m_full = 1'b0;
      clear_pend();
   endtask

   // Apply inputs, predict this edge, then advance to posedge+2.
   task automatic step(input bit ordy);
      int         w;
      int         idx;
      logic [N-1:0] er;
      exp_t       e;
      bus.out_ready = ordy;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]        = pend_v[i];
         bus.req_data[i*W +: W]  = pend_d[i];
      end
      #1;
      w = -1;
      if (!m_full || ordy) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && pend_v[idx]) w = idx;
         end
      end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(er));
      check("out_valid", 32'(bus.out_valid), 32'(m_full));
      if (w >= 0) begin
         e.d = pend_d[w];
         e.g = 3'(w);
         sb.push_back(e);
         pend_v[w] = 1'b0;
         m_ptr     = (w + 1) % N;
         m_full    = 1'b1;
      end else if (m_full && ordy) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int budget;
      rst_n         = 1'b0;
      bus.req_valid = '1;
      bus.req_data  = '1;
      bus.out_ready = 1'b1;
      model_reset();

      // Reset holds everything idle even with all requests raised.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check("rst_req_ready", 32'(bus.req_ready), 32'h0);
         check("rst_out_valid", 32'(bus.out_valid), 32'h0);
         check("rst_out_data", 32'(bus.out_data), 32'h0);
         check("rst_grant_id", 32'(bus.grant_id), 32'h0);
      end

      // Single stream from requester 2.
      do_reset();
      pend_v[2] = 1'b1; pend_d[2] = 11'h123;
      step(1'b1);
      check("ss_data0", 32'(bus.out_data), 32'h123);
      pend_v[2] = 1'b1; pend_d[2] = 11'h456;
      step(1'b1);
      check("ss_data1", 32'(bus.out_data), 32'h456);
      check("ss_gid", 32'(bus.grant_id), 32'h2);
      step(1'b1);
      check("ss_count", 32'(bus.pkt_count), 32'h2);

      // Round robin with everyone requesting.
      do_reset();
      for (int c = 0; c < 11; c++) begin
         for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b1;
            pend_d[i] = 11'(11'h700 + i);
         end
         step(1'b1);
      end
      check("rr_count", 32'(bus.pkt_count), 32'd10);
      check("rr_len_ok", 32'(got_gid.size() >= 10), 32'h1);
      for (int c = 0; c < 10 && c < got_gid.size(); c++)
         check("rr_order", 32'(got_gid[c]), 32'(c % N));

      // Backpressure.
      do_reset();
      pend_v[0] = 1'b1; pend_d[0] = 11'h055;
      step(1'b0);
      pend_v[1] = 1'b1; pend_d[1] = 11'h2AB;
      for (int c = 0; c < 4; c++) begin
         step(1'b0);
         check("bp_hold_data", 32'(bus.out_data), 32'h055);
         check("bp_no_ready", 32'(bus.req_ready), 32'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.req_ready), 32'h2);
      step(1'b1);
      check("bp_new_data", 32'(bus.out_data), 32'h2AB);
      check("bp_new_gid", 32'(bus.grant_id), 32'h1);
      check("bp_delivered", 32'(got_data.size() == 1 && got_data[0] == 11'h055),
            32'h1);
      step(1'b1);

      // Reset in the middle of operation.
      do_reset();
      pend_v[0] = 1'b1; pend_d[0] = 11'h011;
      step(1'b1);
      pend_v[3] = 1'b1; pend_d[3] = 11'h333;
      step(1'b1);
      step(1'b0);
      check("mr_gid_before", 32'(bus.grant_id), 32'h3);
      check("mr_count_before", 32'(bus.pkt_count), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mr_valid_drop", 32'(bus.out_valid), 32'h0);
      check("mr_count_clear", 32'(bus.pkt_count), 32'h0);
      check("mr_gid_clear", 32'(bus.grant_id), 32'h0);
      model_reset();
      rst_n = 1'b1;
      pend_v[3] = 1'b1; pend_d[3] = 11'h3A3;
      pend_v[4] = 1'b1; pend_d[4] = 11'h4A4;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      check("mr_len", 32'(got_gid.size()), 32'h2);
      if (got_gid.size() == 2) begin
         check("mr_first", 32'(got_gid[0]), 32'h3);
         check("mr_second", 32'(got_gid[1]), 32'h4);
      end

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && ($urandom % 3 == 0)) begin
               pend_v[i] = 1'b1;
               pend_d[i] = 11'($urandom);
            end
         end
         step(($urandom % 4) != 0);
      end

      // Counter wrap.
      do_reset();
      budget = 70000;
      while (m_cnt != 16'hFFFF && budget > 0) begin
         pend_v[4] = 1'b1;
         pend_d[4] = 11'($urandom);
         step(1'b1);
         budget--;
      end
      check("wrap_budget", 32'(budget > 0), 32'h1);
      check("wrap_ffff", 32'(bus.pkt_count), 32'hFFFF);
      clear_pend();
      step(1'b1);
      check("wrap_zero", 32'(bus.pkt_count), 32'h0);

      // Drain and confirm nothing is left outstanding.
      clear_pend();
      for (int c = 0; c < 3; c++) step(1'b1);
      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
